bcd_clock_core: RTL and testbench

Parametrised successor to the digital-clock counter: it divides the board clock to a 1 Hz tick and keeps hours, minutes and seconds. It adds run/set control with per-field increment, a 12/24-hour display mode and an alarm with ring duration and acknowledge. It drives the six BCD digit buses consumed by the seven-segment scanner, and its port names are kept compatible with the existing top level.

---
 rtl/bcd_clock_core.sv | 127 ++++++++++++
 tb/tb_bcd_clock_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_clock_core.sv
// Hours/minutes/seconds clock with 1 Hz prescaler, run/set control, 12/24 h display
// and a timed alarm. Digit outputs are combinational BCD decodes of the binary time.
module bcd_clock_core #(
    parameter int CLK_DIV    = 100_000_000,
    parameter int DIV_W      = 27,
    parameter int ALARM_SECS = 30
) (
    input  logic       clkinput,
    input  logic       reset,
    input  logic       run,
    input  logic       inc_Second,
    input  logic       inc_Minute,
    input  logic       inc_Hour,
    input  logic       clr_Second,
    input  logic       hour_mode,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_minute,
    input  logic       alarm_ack,
    output logic [3:0] Second_First,
    output logic [3:0] Second_Second,
    output logic [3:0] Minute_First,
    output logic [3:0] Minute_Second,
    output logic [3:0] Hour_First,
    output logic [3:0] Hour_Second,
    output logic       pm,
    output logic       tick_1hz,
    output logic       alarm
);

    typedef enum logic {S_IDLE, S_RING} state_t;

    logic [DIV_W-1:0] r_div;
    logic [5:0]       r_sec, r_min;
    logic [4:0]       r_hr;
    state_t           r_state;
    logic [7:0]       r_ring_cnt;

    logic             w_tick, w_adv, w_hit;
    logic [5:0]       w_sec_n, w_min_n;
    logic [4:0]       w_hr_n, w_hr_disp;

    assign w_tick = run & (r_div == DIV_W'(CLK_DIV - 1));
    // A tick swallowed by clr_Second neither advances time nor fires the alarm.
    assign w_adv  = w_tick & ~clr_Second;

    always_comb begin
        w_sec_n = r_sec;
        w_min_n = r_min;
        w_hr_n  = r_hr;
        if (run) begin
            if (w_adv) begin
                if (r_sec == 6'd59) begin
                    w_sec_n = 6'd0;
                    if (r_min == 6'd59) begin
                        w_min_n = 6'd0;
                        w_hr_n  = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
                    end else begin
                        w_min_n = r_min + 6'd1;
                    end
                end else begin
                    w_sec_n = r_sec + 6'd1;
                end
            end
        end else begin
            if (inc_Second) w_sec_n = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
            if (inc_Minute) w_min_n = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            if (inc_Hour)   w_hr_n  = (r_hr == 5'd23)  ? 5'd0 : r_hr + 5'd1;
        end
        if (clr_Second) w_sec_n = 6'd0;
    end

    assign w_hit = w_adv & alarm_en & (w_sec_n == 6'd0) &
                   (w_min_n == alarm_minute) & (w_hr_n == alarm_hour);

    always_ff @(posedge clkinput or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_sec      <= '0;
            r_min      <= '0;
            r_hr       <= '0;
            r_state    <= S_IDLE;
            r_ring_cnt <= '0;
        end else begin
            r_div <= (clr_Second || !run || w_tick) ? '0 : r_div + DIV_W'(1);
            r_sec <= w_sec_n;
            r_min <= w_min_n;
            r_hr  <= w_hr_n;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_state    <= S_RING;
                        r_ring_cnt <= 8'd0;
                    end
                end
                S_RING: begin
                    if (alarm_ack || !alarm_en) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        if (r_ring_cnt + 8'd1 == 8'(ALARM_SECS)) r_state <= S_IDLE;
                        r_ring_cnt <= r_ring_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_hr_disp = r_hr;
        if (hour_mode) begin
            if (r_hr == 5'd0)      w_hr_disp = 5'd12;
            else if (r_hr > 5'd12) w_hr_disp = r_hr - 5'd12;
        end
    end

    assign Second_Second = 4'(r_sec / 6'd10);
    assign Second_First  = 4'(r_sec % 6'd10);
    assign Minute_Second = 4'(r_min / 6'd10);
    assign Minute_First  = 4'(r_min % 6'd10);
    assign Hour_Second   = 4'(w_hr_disp / 5'd10);
    assign Hour_First    = 4'(w_hr_disp % 5'd10);
    assign pm            = (r_hr >= 5'd12);
    assign tick_1hz      = w_tick;
    assign alarm         = (r_state == S_RING);

endmodule

// File: tb/tb_bcd_clock_core.sv
// Bench for bcd_clock_core: directed scenarios plus random stimulus, all checked
// against a seconds-of-day reference model.
module tb_bcd_clock_core;
    localparam int CD = 4;
    localparam int AS = 3;

    logic clk = 0, rst_n = 0, run = 0, inc_s = 0, inc_m = 0, inc_h = 0, clr = 0;
    logic hmode = 0, aen = 0, ack = 0;
    logic [4:0] ahr = 0;
    logic [5:0] amin = 0;
    logic [3:0] s1, s10, m1, m10, h1, h10;
    logic pm, tick_1hz, alarm;
    logic [23:0] w_dig;

    bcd_clock_core #(.CLK_DIV(CD), .DIV_W(3), .ALARM_SECS(AS)) dut (
        .clkinput(clk), .reset(rst_n), .run(run),
        .inc_Second(inc_s), .inc_Minute(inc_m), .inc_Hour(inc_h),
        .clr_Second(clr), .hour_mode(hmode), .alarm_en(aen),
        .alarm_hour(ahr), .alarm_minute(amin), .alarm_ack(ack),
        .Second_First(s1), .Second_Second(s10), .Minute_First(m1), .Minute_Second(m10),
        .Hour_First(h1), .Hour_Second(h10), .pm(pm), .tick_1hz(tick_1hz), .alarm(alarm));

    assign w_dig = {h10, h1, m10, m1, s10, s1};
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    // model: time as seconds of day, prescaler phase, ring state and remaining ticks
    int m_t = 0, m_ph = 0, m_rem = 0;
    bit m_ring = 0, m_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_digits();
        int h, m, s, dh;
        h  = m_t / 3600;
        m  = (m_t / 60) % 60;
        s  = m_t % 60;
        dh = hmode ? ((h + 11) % 12 + 1) : h;
        return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // one clock: check tick before the edge, advance model, check state after the edge
    task automatic cyc();
        bit tk, ring_n;
        int h, m, s, tn, ph_n, rem_n;
        @(negedge clk);
        tk = rst_n && run && (m_ph == CD - 1);
        m_seen = tick_1hz;
        chk("tick", tick_1hz, tk);
        h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        ring_n = m_ring; rem_n = m_rem;
        if (!rst_n) begin
            tn = 0; ph_n = 0; ring_n = 0; rem_n = 0;
        end else begin
            ph_n = (clr || !run || tk) ? 0 : m_ph + 1;
            if (run) tn = (tk && !clr) ? (m_t + 1) % 86400 : m_t;
            else     tn = ((h + inc_h) % 24) * 3600 + ((m + inc_m) % 60) * 60 + (s + inc_s) % 60;
            if (clr) tn = tn - tn % 60;
            if (!m_ring) begin
                if (tk && !clr && aen && int'(ahr) < 24 && int'(amin) < 60 &&
                    tn == int'(ahr) * 3600 + int'(amin) * 60) begin
                    ring_n = 1; rem_n = AS;
                end
            end else if (ack || !aen) begin
                ring_n = 0;
            end else if (tk) begin
                rem_n = m_rem - 1;
                if (rem_n == 0) ring_n = 0;
            end
        end
        @(posedge clk);
        #1;
        m_t = tn; m_ph = ph_n; m_ring = ring_n; m_rem = rem_n;
        inc_s = 0; inc_m = 0; inc_h = 0; clr = 0; ack = 0;
        chk("digits", w_dig, exp_digits());
        chk("pm", pm, (m_t / 3600) >= 12);
        chk("alarm", alarm, m_ring);
    endtask

    task automatic set_time(input int th, input int tm, input int ts);
        int n;
        run = 0;
        cyc();
        n = (th - m_t / 3600 + 24) % 24;
        repeat (n) begin inc_h = 1; cyc(); end
        n = (tm - (m_t / 60) % 60 + 60) % 60;
        repeat (n) begin inc_m = 1; cyc(); end
        n = (ts - m_t % 60 + 60) % 60;
        repeat (n) begin inc_s = 1; cyc(); end
    endtask

    task automatic wait_alarm(input string tag);
        int k = 0;
        while (!alarm && k < 60) begin cyc(); k++; end
        chk(tag, alarm, 1);
    endtask

    initial begin
        int ticks, last, hi, n;

        // reset state
        repeat (3) cyc();
        chk("rst_dig", w_dig, 24'h000000);
        hmode = 1; #1;
        chk("rst_12h", w_dig, 24'h120000);
        hmode = 0; #1;

        // free run: 60 ticks 4 cycles apart
        rst_n = 1; run = 1; ticks = 0; last = -1;
        for (int i = 0; i < 240; i++) begin
            cyc();
            if (m_seen) begin
                if (last >= 0) chk("tick_gap", i - last, CD);
                last = i; ticks++;
            end
        end
        chk("tick_cnt", ticks, 60);
        chk("t000100", w_dig, 24'h000100);

        // midnight wrap
        set_time(23, 59, 58);
        run = 1; ticks = 0; n = 0;
        while (ticks < 2 && n < 20) begin
            cyc(); n++;
            if (m_seen) begin
                ticks++;
                if (ticks == 1) begin chk("t235959", w_dig, 24'h235959); chk("pm_hi", pm, 1); end
                else begin chk("t000000", w_dig, 24'h000000); chk("pm_lo", pm, 0); end
            end
        end
        chk("wrap_ticks", ticks, 2);

        // set mode: 25 hour pulses, no carry; 12 h display
        set_time(0, 7, 33);
        repeat (25) begin inc_h = 1; cyc(); end
        chk("hr25", w_dig, 24'h010733);
        set_time(13, 7, 33);
        hmode = 1; #1;
        chk("h12_13", w_dig[23:16], 8'h01);
        chk("pm_13", pm, 1);
        set_time(0, 7, 33);
        chk("h12_00", w_dig[23:16], 8'h12);
        chk("pm_00", pm, 0);
        hmode = 0; #1;

        // alarm timeout after AS ticks
        ahr = 0; amin = 2; aen = 1;
        set_time(0, 1, 58);
        run = 1;
        wait_alarm("alarm_rise");
        chk("alarm_time", w_dig, 24'h000200);
        hi = 0;
        while (alarm && hi < 40) begin cyc(); hi++; end
        chk("ring_len", hi, AS * CD);

        // alarm acknowledge
        set_time(0, 1, 58);
        run = 1;
        wait_alarm("alarm_rise2");
        repeat (CD) cyc();
        chk("ring_hold", alarm, 1);
        ack = 1; cyc();
        chk("ack_drop", alarm, 0);
        aen = 0;

        // clr_Second on a tick at 00:05:59
        set_time(0, 5, 59);
        run = 1;
        repeat (CD - 1) cyc();
        chk("tick_pre", tick_1hz, 1);
        clr = 1; cyc();
        chk("clr_time", w_dig, 24'h000500);
        n = 1;
        while (!tick_1hz && n < 10) begin cyc(); n++; end
        chk("clr_gap", n, CD);

        // async reset while ringing at 12:34:56
        ahr = 12; amin = 34; aen = 1;
        set_time(12, 33, 58);
        run = 1;
        wait_alarm("alarm_rise3");
        set_time(12, 34, 56);
        chk("ring_12", alarm, 1);
        chk("t123456", w_dig, 24'h123456);
        rst_n = 0; #1;
        chk("arst_dig", w_dig, 24'h000000);
        chk("arst_alarm", alarm, 0);
        chk("arst_pm", pm, 0);
        chk("arst_tick", tick_1hz, 0);
        cyc();
        rst_n = 1;

        // random stimulus
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom % 16) != 0;
            if (!run) begin
                inc_s = ($urandom % 3) == 0;
                inc_m = ($urandom % 3) == 0;
                inc_h = ($urandom % 3) == 0;
            end
            clr = ($urandom % 50) == 0;
            ack = ($urandom % 30) == 0;
            aen = ($urandom % 40) != 0;
            if ($urandom % 8 == 0) hmode = ~hmode;
            if (i % 100 == 0) begin
                ahr  = 5'((m_t / 3600 + (($urandom % 6 == 0) ? 24 : 0)) % 32);
                amin = 6'(((m_t / 60) % 60 + 1) % 60);
            end
            if (i % 997 == 500) rst_n = 0;
            cyc();
            rst_n = 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
